// File: rtl/bkg_scroll_ctrl.sv
// Background horizontal scroll controller: steps scroll_x toward a requested target
// once per frame and produces the registered background ROM address.
module bkg_scroll_ctrl #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int MAP_W    = 2048,
   parameter int ADDR_W   = 20,
   parameter int STEP     = 4
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              scroll_req,
   input  logic [10:0]       scroll_target,
   output logic              scroll_ack,
   output logic              busy,
   output logic              scroll_done,
   output logic [10:0]       scroll_x,
   output logic [ADDR_W-1:0] rom_address
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_STEP  = 2'd2;

   localparam int               AW1        = ADDR_W + 1;
   localparam logic [10:0]      MAX_SCROLL = 11'(MAP_W - SCREEN_W);
   localparam logic [10:0]      STEP_U     = 11'(STEP);
   localparam logic signed [11:0] STEP_POS = 12'(STEP);
   localparam logic signed [11:0] STEP_NEG = 12'(-STEP);

   logic [1:0]        state_q, state_d;
   logic [10:0]       target_q, target_d;
   logic [10:0]       scroll_x_q, scroll_x_d;
   logic              ack_q, ack_d;
   logic              done_q, done_d;
   logic              corner_q, corner_d;
   logic [ADDR_W-1:0] rom_address_q, rom_address_d;

   logic              at_corner;
   logic              frame_tick;
   logic signed [11:0] diff;
   logic [ADDR_W:0]   addr_sum;

   // The corner may be held for several vga_clk cycles; only its first cycle ticks.
   assign at_corner  = (DrawX == 10'(SCREEN_W - 1)) && (DrawY == 10'(SCREEN_H - 1));
   assign frame_tick = at_corner && !corner_q;

   always_comb begin
      corner_d      = at_corner;
      addr_sum      = AW1'(DrawY) * AW1'(MAP_W) + AW1'(DrawX) + AW1'(scroll_x_q);
      rom_address_d = addr_sum[ADDR_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      scroll_x_d = scroll_x_q;
      ack_d      = 1'b0;
      done_d     = 1'b0;
      diff       = $signed({1'b0, target_q}) - $signed({1'b0, scroll_x_q});
      case (state_q)
         S_IDLE: begin
            if (scroll_req) begin
               target_d = (scroll_target > MAX_SCROLL) ? MAX_SCROLL : scroll_target;
               ack_d    = 1'b1;
               state_d  = S_ARMED;
            end
         end
         S_ARMED: begin
            if (frame_tick) begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            if ((diff <= STEP_POS) && (diff >= STEP_NEG)) begin
               scroll_x_d = target_q;
               done_d     = 1'b1;
               state_d    = S_IDLE;
            end else if (diff > 12'sd0) begin
               scroll_x_d = scroll_x_q + STEP_U;
               state_d    = S_ARMED;
            end else begin
               scroll_x_d = scroll_x_q - STEP_U;
               state_d    = S_ARMED;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         target_q      <= '0;
         scroll_x_q    <= '0;
         ack_q         <= 1'b0;
         done_q        <= 1'b0;
         corner_q      <= 1'b1;
         rom_address_q <= '0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         scroll_x_q    <= scroll_x_d;
         ack_q         <= ack_d;
         done_q        <= done_d;
         corner_q      <= corner_d;
         rom_address_q <= rom_address_d;
      end
   end

   assign scroll_ack  = ack_q;
   assign scroll_done = done_q;
   assign busy        = (state_q != S_IDLE);
   assign scroll_x    = scroll_x_q;
   assign rom_address = rom_address_q;

endmodule

// File: tb/tb_bkg_scroll_ctrl.sv
// Scoreboard bench for bkg_scroll_ctrl: stimulus queues expected ack/step/done
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_bkg_scroll_ctrl;

   localparam int K_ACK  = 0;
   localparam int K_STEP = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic        vga_clk;
   logic        reset_n;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        scroll_req;
   logic [10:0] scroll_target;
   logic        scroll_ack;
   logic        busy;
   logic        scroll_done;
   logic [10:0] scroll_x;
   logic [19:0] rom_address;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  prev_x   = 0;
   time last_done_t = 0;
   int  hn;

   bkg_scroll_ctrl dut (
      .vga_clk       (vga_clk),
      .reset_n       (reset_n),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .scroll_req    (scroll_req),
      .scroll_target (scroll_target),
      .scroll_ack    (scroll_ack),
      .busy          (busy),
      .scroll_done   (scroll_done),
      .scroll_x      (scroll_x),
      .rom_address   (rom_address)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end else begin
         $display("ok   %s: %0d at %0t", name, actual, $time);
      end
   endtask

   task automatic push(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_event: got kind=%0d x=%0d expected none at %0t", kind, val, $time);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("event_kind(exp %0d)", e.kind), kind, e.kind);
         check("event_scroll_x", val, e.val);
      end
   endtask

   // Monitor: every ack/done pulse and every change of scroll_x is an event.
   always @(negedge vga_clk) begin
      if (!reset_n) begin
         prev_x = int'(scroll_x);
      end else begin
         if (scroll_ack) pop_check(K_ACK, 0);
         if (scroll_done) begin
            pop_check(K_DONE, int'(scroll_x));
            last_done_t = $time;
         end else if (int'(scroll_x) != prev_x) begin
            pop_check(K_STEP, int'(scroll_x));
         end
         prev_x = int'(scroll_x);
      end
   end

   task automatic tick(input int hold);
      @(negedge vga_clk);
      DrawX = 10'd639;
      DrawY = 10'd479;
      repeat (hold - 1) @(negedge vga_clk);
      @(negedge vga_clk);
      DrawX = 10'd0;
      DrawY = 10'd0;
      @(negedge vga_clk);
   endtask

   task automatic do_req(input int t);
      int n;
      push(K_ACK, 0);
      @(negedge vga_clk);
      scroll_req    = 1'b1;
      scroll_target = 11'(t);
      n = 0;
      do begin
         @(negedge vga_clk);
         n++;
      end while (!scroll_ack && n < 50);
      check("ack_latency", n, 1);
      scroll_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      DrawX         = 10'd5;
      DrawY         = 10'd2;
      scroll_req    = 1'b0;
      scroll_target = '0;

      // 1: reset state and address latency
      repeat (2) @(negedge vga_clk);
      check("reset_rom_address", rom_address, 0);
      check("reset_scroll_x", scroll_x, 0);
      check("reset_busy", busy, 0);
      check("reset_ack", scroll_ack, 0);
      check("reset_done", scroll_done, 0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      check("rom_address_5_2", rom_address, 4101);
      DrawX = 10'd0;
      DrawY = 10'd0;

      // 2: forward 0 -> 10
      do_req(10);
      check("busy_after_ack", busy, 1);
      push(K_STEP, 4);
      push(K_STEP, 8);
      push(K_DONE, 10);
      repeat (3) tick(1);
      check("busy_after_done", busy, 0);
      check("scroll_x_10", scroll_x, 10);

      // 3: saturating target 2000 -> 1408
      do_req(2000);
      for (int k = 1; k <= 349; k++) push(K_STEP, 10 + 4 * k);
      push(K_DONE, 1408);
      repeat (350) tick(1);
      check("scroll_x_max", scroll_x, 1408);
      @(negedge vga_clk);
      DrawX = 10'd639;
      DrawY = 10'd479;
      @(negedge vga_clk);
      check("rom_address_corner", rom_address, 983039);
      DrawX = 10'd0;
      DrawY = 10'd0;

      // 4: back to 10 with a second request held while busy, then 10 -> 2
      do_req(10);
      for (int k = 1; k <= 349; k++) push(K_STEP, 1408 - 4 * k);
      push(K_DONE, 10);
      push(K_ACK, 0);
      push(K_STEP, 6);
      push(K_DONE, 2);
      fork
         begin
            @(negedge vga_clk);
            scroll_req    = 1'b1;
            scroll_target = 11'd2;
            hn = 0;
            do begin
               @(negedge vga_clk);
               hn++;
            end while (!scroll_ack && hn < 3000);
            check("held_ack_delay_after_done", longint'($time - last_done_t), 10);
            scroll_req = 1'b0;
         end
      join_none
      repeat (350) tick(1);
      repeat (2) tick(1);
      check("scroll_x_2", scroll_x, 2);

      // 5: corner held for two cycles gives a single step
      do_req(40);
      for (int k = 1; k <= 9; k++) push(K_STEP, 2 + 4 * k);
      push(K_DONE, 40);
      tick(2);
      check("single_step_on_held_corner", scroll_x, 6);
      repeat (9) tick(1);
      check("scroll_x_40", scroll_x, 40);

      // 6: reset while ARMED discards the target
      do_req(100);
      @(negedge vga_clk);
      reset_n = 1'b0;
      repeat (2) @(negedge vga_clk);
      check("reset_armed_scroll_x", scroll_x, 0);
      check("reset_armed_busy", busy, 0);
      reset_n = 1'b1;
      tick(1);
      check("no_step_after_reset", scroll_x, 0);
      do_req(8);
      push(K_STEP, 4);
      push(K_DONE, 8);
      repeat (2) tick(1);
      check("scroll_x_8", scroll_x, 8);

      repeat (5) @(negedge vga_clk);
      check("pending_events", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
